m_axis_rc_fifo: RTL and testbench
=================================

# m_axis_rc_fifo

- Packet-aware elastic buffer on the Requester Completion (RC) path.
- Sits between the PCIe hard IP `m_axis_rc` master and the RC adapter's `_a` input, so the RC stream is decoupled from adapter backpressure.
- Stores beats unchanged in native hard-IP format: data, dword keep, last and 85-bit user sideband.
- Presents them first-word-fall-through on a fully registered output, and tracks occupancy and the count of complete packets held.

## Interface
Parameters:
- `DATA_WIDTH`, 128, beat width in bits; legal values 128, 256, 512.
- `KEEP_WIDTH`, DATA_WIDTH/8, byte-keep width; dword keep is KEEP_WIDTH/4.
- `DEPTH`, 16, beat capacity; power of two, ≥4.

Ports:
- `user_clk` in 1: the only clock.
- `user_reset_n` in 1: reset, synchronous, active-low.
- `s_axis_rc_tdata` in DATA_WIDTH: beat data from the hard IP.
- `s_axis_rc_tkeep` in KEEP_WIDTH/4: dword keep.
- `s_axis_rc_tlast` in 1: last beat of the packet.
- `s_axis_rc_tuser` in 85: sideband.
- `s_axis_rc_tvalid` in 1: upstream beat valid.
- `s_axis_rc_tready` out 4: all four bits carry the same ready value.
- `m_axis_rc_tdata_a` out DATA_WIDTH: beat data to the adapter.
- `m_axis_rc_tkeep_a` out KEEP_WIDTH/4: dword keep.
- `m_axis_rc_tlast_a` out 1: last beat.
- `m_axis_rc_tuser_a` out 85: sideband.
- `m_axis_rc_tvalid_a` out 1: output beat valid.
- `m_axis_rc_tready_a` in 4: only bit 0 is used.
- `level` out clog2(DEPTH)+1: beats held.
- `pkt_count` out clog2(DEPTH)+1: complete packets held, counted by stored tlast beats.

## Operation
Storage and pointers:
- Storage is an array of DEPTH entries, each {tdata, tkeep, tlast, tuser}.
- Write and read pointers are clog2(DEPTH)+1 bits and wrap naturally.
- full = (level == DEPTH); empty = (level == 0).

Write side:
- Write strobe wr = s_axis_rc_tvalid & ready.
- ready = user_reset_n & !full.
- ready depends only on the registered level. A read in the same cycle does not open a slot in a full FIFO; there is no pass-through when full.

Read side:
- Output stage is one register: out_valid plus the out_* fields.
- The output register loads the head entry when it is empty, or when it is being consumed (out_valid & m_axis_rc_tready_a[0]) and another entry is eligible.
- `level` counts entries in the array plus the output register. It does +1 on wr, −1 on consume, and stays unchanged when both occur.
- `pkt_count` does +1 on wr of a tlast beat, −1 on consume of a tlast beat, and stays unchanged when both occur.

Output stability:
- While out_valid=1 and m_axis_rc_tready_a[0]=0, every m_axis_rc_*_a output holds stable.

Reset:
- user_reset_n low at any cycle, including mid-packet, sets on the next edge: pointers=0, level=0, pkt_count=0, m_axis_rc_tvalid_a=0, m_axis_rc_tdata_a/tkeep_a/tlast_a/tuser_a=0.
- s_axis_rc_tready=4'b0 combinationally while reset is low.
- Partial packets are discarded. Array contents are not cleared.

## Timing
- Latency: a beat written at edge N into an empty FIFO is on m_axis_rc_*_a with tvalid=1 after edge N+1.
- Throughput: one beat per cycle sustained when m_axis_rc_tready_a[0]=1 and 0 < level < DEPTH.
- s_axis_rc_tready falls in the cycle after the write that makes level reach DEPTH.
- s_axis_rc_tready rises in the cycle after the first consume from full.
- m_axis_rc_tvalid_a is never deasserted without a consume.
- Outputs are registered; the only combinational path is reset to s_axis_rc_tready.

## Configuration
- `M_AXIS_RC_FIFO_STORE_FORWARD_EN` defined (store-and-forward):
  - The head beat is eligible for the output register only when pkt_count > 0, or when a packet is already in progress on the output.
  - A packet in progress means a first beat has been consumed and no tlast beat has been consumed since.
  - Deadlock release: if full=1 and pkt_count=0, the head becomes eligible, and the packet streams cut-through to completion.
- Macro undefined (cut-through): any stored beat is eligible immediately, and pkt_count only serves as status.

## Test plan
- Reset then single beat: release reset; 4-beat packet written back-to-back with tready_a=4'hF → output beats 1–4 appear on cycles 2–5, tlast on beat 4; level returns to 0 and pkt_count returns to 0.
- Full backpressure: tready_a=0 with continuous writes → exactly 16 beats accepted; s_axis_rc_tready=4'h0 after the 16th; level=16. Then one consume → tready=4'hF the next cycle; no beat lost or duplicated.
- Simultaneous read/write at level=8 → level stays 8 and pkt_count stays stable; payload order is preserved across a pointer wrap of 40 beats.
- Output hold: tready_a toggles 1010… during a 6-beat packet → each output beat holds until consumed, and data matches the input sequence exactly.
- Mid-packet reset: assert user_reset_n=0 after beat 2 of 5 → next cycle tvalid_a=0, level=0, pkt_count=0; a subsequent 3-beat packet is output intact.
- With `M_AXIS_RC_FIFO_STORE_FORWARD_EN`:
  - A 3-beat packet with a 5-cycle gap before its tlast beat → tvalid_a stays 0 until the cycle after tlast is written.
  - A 20-beat packet → released when level=16, and all 20 beats are delivered.

Source files
------------

// File: rtl/m_axis_rc_fifo_if.sv
// RC AXI-Stream beat bundle in native hard-IP format.
// tready is four bits wide to match the hard-IP port.
interface m_axis_rc_fifo_if #(
  parameter int DATA_WIDTH = 128
);
  localparam int DKW = DATA_WIDTH / 32;

  logic [DATA_WIDTH-1:0] tdata;
  logic [DKW-1:0]        tkeep;
  logic                  tlast;
  logic [84:0]           tuser;
  logic                  tvalid;
  logic [3:0]            tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/m_axis_rc_fifo.sv
// Packet-aware FWFT elastic buffer for the RC stream, registered output.
// Define M_AXIS_RC_FIFO_STORE_FORWARD_EN for store-and-forward release.
module m_axis_rc_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1,
  localparam int DKW       = KEEP_WIDTH / 4
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
  input  logic [DKW-1:0]        s_axis_rc_tkeep,
  input  logic                  s_axis_rc_tlast,
  input  logic [84:0]           s_axis_rc_tuser,
  input  logic                  s_axis_rc_tvalid,
  output logic [3:0]            s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a,
  output logic [DKW-1:0]        m_axis_rc_tkeep_a,
  output logic                  m_axis_rc_tlast_a,
  output logic [84:0]           m_axis_rc_tuser_a,
  output logic                  m_axis_rc_tvalid_a,
  input  logic [3:0]            m_axis_rc_tready_a,
  output logic [CW-1:0]         level,
  output logic [CW-1:0]         pkt_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DKW-1:0]        keep;
    logic                  last;
    logic [84:0]           user;
  } beat_t;

  beat_t          mem_q [DEPTH];
  beat_t          out_q, out_d;
  beat_t          wr_beat;
  logic           out_vld_q, out_vld_d;
  logic [CW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  level_q, level_d;
  logic [CW-1:0]  pkt_q, pkt_d;
  logic           full, rdy, wr, consume;
  logic           arr_ne, elig, load;
  logic [2:0]     unused_tready;

  assign unused_tready = m_axis_rc_tready_a[3:1];

  assign full    = (level_q == CW'(DEPTH));
  assign rdy     = user_reset_n & ~full;
  assign wr      = s_axis_rc_tvalid & rdy;
  assign consume = out_vld_q & m_axis_rc_tready_a[0];
  assign arr_ne  = (wptr_q != rptr_q);
  assign load    = arr_ne & elig & (~out_vld_q | consume);

  assign wr_beat = {s_axis_rc_tdata, s_axis_rc_tkeep,
                    s_axis_rc_tlast, s_axis_rc_tuser};

`ifdef M_AXIS_RC_FIFO_STORE_FORWARD_EN
  logic          in_pkt_q;
  logic          in_prog;
  logic [CW-1:0] arr_pkts;

  // Packets wholly in the array; a tail sitting in the output is excluded.
  assign arr_pkts = pkt_q - CW'(out_vld_q & out_q.last);
  assign in_prog  = out_vld_q ? ~out_q.last : in_pkt_q;
  assign elig     = (arr_pkts != '0) | in_prog |
                    (full & (pkt_q == '0));

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      in_pkt_q <= 1'b0;
    end else if (consume) begin
      in_pkt_q <= ~out_q.last;
    end
  end
`else
  assign elig = 1'b1;
`endif

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    level_d   = level_q + CW'(wr) - CW'(consume);
    pkt_d     = pkt_q + CW'(wr & s_axis_rc_tlast)
              - CW'(consume & out_q.last);
    if (wr) begin
      wptr_d = wptr_q + CW'(1);
    end
    if (load) begin
      rptr_d    = rptr_q + CW'(1);
      out_d     = mem_q[rptr_q[AW-1:0]];
      out_vld_d = 1'b1;
    end else if (consume) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (wr) begin
      mem_q[wptr_q[AW-1:0]] <= wr_beat;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      pkt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      pkt_q     <= pkt_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  assign s_axis_rc_tready   = {4{rdy}};
  assign m_axis_rc_tdata_a  = out_q.data;
  assign m_axis_rc_tkeep_a  = out_q.keep;
  assign m_axis_rc_tlast_a  = out_q.last;
  assign m_axis_rc_tuser_a  = out_q.user;
  assign m_axis_rc_tvalid_a = out_vld_q;
  assign level              = level_q;
  assign pkt_count          = pkt_q;

endmodule

// File: tb/tb_m_axis_rc_fifo.sv
// Scoreboard bench for m_axis_rc_fifo: directed packets, queue-based
// monitor for order and payload, plus hold-stability checking.
`timescale 1ns/1ps
module tb_m_axis_rc_fifo;
  localparam int DW = 128;
  localparam int CW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    keep;
    logic          last;
    logic [84:0]   user;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_axis_rc_fifo_if #(.DATA_WIDTH(DW)) up ();
  m_axis_rc_fifo_if #(.DATA_WIDTH(DW)) dn ();
  logic [CW-1:0] level, pkt_count;

  m_axis_rc_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
    .user_clk           (clk),
    .user_reset_n       (rst_n),
    .s_axis_rc_tdata    (up.tdata),
    .s_axis_rc_tkeep    (up.tkeep),
    .s_axis_rc_tlast    (up.tlast),
    .s_axis_rc_tuser    (up.tuser),
    .s_axis_rc_tvalid   (up.tvalid),
    .s_axis_rc_tready   (up.tready),
    .m_axis_rc_tdata_a  (dn.tdata),
    .m_axis_rc_tkeep_a  (dn.tkeep),
    .m_axis_rc_tlast_a  (dn.tlast),
    .m_axis_rc_tuser_a  (dn.tuser),
    .m_axis_rc_tvalid_a (dn.tvalid),
    .m_axis_rc_tready_a (dn.tready),
    .level              (level),
    .pkt_count          (pkt_count)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  beat_t cur, e, prev_b, t;
  logic  prev_hold = 1'b0;

  function automatic beat_t mk(input int seq, input bit last);
    beat_t b;
    b.data = {32'hC0DE_0000 + 32'(seq), ~32'(seq),
              32'(seq * 7), 32'(seq)};
    b.keep = last ? 4'h7 : 4'hF;
    b.last = last;
    b.user = {53'h0, 32'(seq * 13 + 1)};
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input beat_t b);
    up.tdata  = b.data;
    up.tkeep  = b.keep;
    up.tlast  = b.last;
    up.tuser  = b.user;
    up.tvalid = 1'b1;
  endtask

  task automatic send(input int seq, input bit last);
    bit done;
    done = 1'b0;
    drive(mk(seq, last));
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = up.tready[0];
      @(posedge clk);
      #1;
    end
    up.tvalid = 1'b0;
    chk("send_accept", 128'(done), 128'(1));
  endtask

  task automatic drain();
    dn.tready = 4'hF;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !dn.tvalid) break;
      step(1);
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_valid", 128'(dn.tvalid), 128'(0));
  endtask

  // Monitor: record accepted inputs, compare each consumed output.
  always @(negedge clk) begin
    cur = {dn.tdata, dn.tkeep, dn.tlast, dn.tuser};
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_cmp++;
        if (cur !== prev_b || dn.tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL hold: got %0h v=%0b expected %0h v=1",
                   cur, dn.tvalid, prev_b);
        end
      end
      if (up.tvalid && up.tready[0])
        exp_q.push_back({up.tdata, up.tkeep, up.tlast, up.tuser});
      if (dn.tvalid && dn.tready[0]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL beat: got %0h expected %0h", cur, e);
          end
        end
      end
      prev_hold = dn.tvalid && !dn.tready[0];
      prev_b    = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    up.tvalid = 1'b0;
    up.tdata  = '0;
    up.tkeep  = '0;
    up.tlast  = 1'b0;
    up.tuser  = '0;
    dn.tready = 4'h0;
    step(3);
    chk("rst_tready", 128'(up.tready), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_pkt", 128'(pkt_count), 128'(0));
    chk("rst_valid", 128'(dn.tvalid), 128'(0));
    chk("rst_data", dn.tdata, 128'(0));
    rst_n = 1'b1;
    step(1);
    chk("tready_up", 128'(up.tready), 128'hF);

    // 4-beat packet, sink always ready
    dn.tready = 4'hF;
    send(1, 0);
`ifndef M_AXIS_RC_FIFO_STORE_FORWARD_EN
    chk("lat_n_valid", 128'(dn.tvalid), 128'(0));
    chk("lat_n_level", 128'(level), 128'(1));
`endif
    send(2, 0);
`ifndef M_AXIS_RC_FIFO_STORE_FORWARD_EN
    t = mk(1, 0);
    chk("lat_n1_valid", 128'(dn.tvalid), 128'(1));
    chk("lat_n1_data", dn.tdata, t.data);
`endif
    send(3, 0);
    send(4, 1);
    drain();
    chk("t1_level", 128'(level), 128'(0));
    chk("t1_pkt", 128'(pkt_count), 128'(0));

    // fill to full under backpressure
    dn.tready = 4'h0;
    for (int i = 0; i < 16; i++) send(100 + i, (i % 4) == 3);
    chk("full_tready", 128'(up.tready), 128'h0);
    chk("full_level", 128'(level), 128'(16));
    chk("full_pkt", 128'(pkt_count), 128'(4));
    drive(mk(116, 1));
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("full_blocked", 128'(up.tready), 128'h0);
      chk("full_hold_lvl", 128'(level), 128'(16));
    end
    dn.tready = 4'hF;
    step(1);
    dn.tready = 4'h0;
    chk("pop_tready", 128'(up.tready), 128'hF);
    chk("pop_level", 128'(level), 128'(15));
    step(1);
    up.tvalid = 1'b0;
    chk("refill_level", 128'(level), 128'(16));
    chk("refill_pkt", 128'(pkt_count), 128'(5));
    drain();
    chk("t2_pkt", 128'(pkt_count), 128'(0));

    // steady state at level 8 across a pointer wrap
    dn.tready = 4'h0;
    for (int i = 0; i < 8; i++) send(200 + i, (i % 4) == 3);
    chk("l8_level", 128'(level), 128'(8));
    chk("l8_pkt", 128'(pkt_count), 128'(2));
    dn.tready = 4'hF;
    for (int i = 0; i < 40; i++) begin
      send(208 + i, (i % 4) == 3);
      chk("rw_level", 128'(level), 128'(8));
      chk("rw_pkt", 128'(pkt_count), 128'(2));
    end
    drain();

    // sink toggles ready during a 6-beat packet
    begin
      int k;
      k = 0;
      for (int c = 0; c < 20; c++) begin
        dn.tready = (c % 2 == 0) ? 4'hF : 4'h0;
        if (k < 6) begin
          drive(mk(300 + k, k == 5));
          k++;
        end else begin
          up.tvalid = 1'b0;
        end
        step(1);
      end
      up.tvalid = 1'b0;
    end
    drain();

    // reset in the middle of a packet
    dn.tready = 4'h0;
    send(400, 0);
    send(401, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_tready", 128'(up.tready), 128'h0);
    step(1);
    chk("mrst_valid", 128'(dn.tvalid), 128'(0));
    chk("mrst_level", 128'(level), 128'(0));
    chk("mrst_pkt", 128'(pkt_count), 128'(0));
    exp_q.delete();
    rst_n = 1'b1;
    step(1);
    dn.tready = 4'hF;
    send(410, 0);
    send(411, 0);
    send(412, 1);
    drain();
    chk("mrst_end_lvl", 128'(level), 128'(0));

`ifdef M_AXIS_RC_FIFO_STORE_FORWARD_EN
    // packet held until its tlast is stored
    dn.tready = 4'hF;
    send(500, 0);
    send(501, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("sf_gap_valid", 128'(dn.tvalid), 128'(0));
    end
    send(502, 1);
    chk("sf_tl_valid", 128'(dn.tvalid), 128'(0));
    step(1);
    chk("sf_rel_valid", 128'(dn.tvalid), 128'(1));
    drain();
`endif

    // oversize packet: released by the full-FIFO rule in store-forward
    dn.tready = 4'hF;
    for (int i = 0; i < 16; i++) send(600 + i, 0);
`ifdef M_AXIS_RC_FIFO_STORE_FORWARD_EN
    chk("sf20_level", 128'(level), 128'(16));
    chk("sf20_valid", 128'(dn.tvalid), 128'(0));
`endif
    for (int i = 16; i < 20; i++) send(600 + i, i == 19);
    drain();
    chk("big_level", 128'(level), 128'(0));
    chk("big_pkt", 128'(pkt_count), 128'(0));

    chk("final_queue", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
